lab2_proc_muldiv_unit: RTL and testbench

LAB2_PROC_MULDIV_UNIT -- requirements
Module: lab2_proc_muldiv_unit

---
 rtl/lab2_proc_muldiv_unit.sv | 78 +++++++
 tb/tb_lab2_proc_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_muldiv_unit.sv
// lab2_proc_muldiv_unit: iterative RISC-V M-extension multiply/divide unit, one shift-add/shift-subtract step per cycle
module lab2_proc_muldiv_unit #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2:0]         req_fn,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  input  logic               kill,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_result,
  output logic               busy
);
  localparam int CW = $clog2(p_nbits) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t               state_q, state_d;
  logic [2:0]           fn_q;
  logic                 neg_q, neg_d;
  logic [p_nbits-1:0]   b_q, a_mag, b_mag, dres, res;
  logic [2*p_nbits-1:0] acc_q, acc_d, mul_step, div_step, prod;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [p_nbits:0]     add, cand, diff;
  logic                 a_sgn, b_sgn, accept, last;
  assign a_sgn  = req_a[p_nbits-1] & (req_fn inside {3'd1, 3'd3, 3'd4, 3'd6});
  assign b_sgn  = req_b[p_nbits-1] & (req_fn inside {3'd1, 3'd4, 3'd6});
  assign a_mag  = a_sgn ? -req_a : req_a;
  assign b_mag  = b_sgn ? -req_b : req_b;
  // DIV by zero keeps the unsigned all-ones quotient; REM keeps a's sign so |a| restores a
  assign neg_d  = (req_fn == 3'd6) ? a_sgn : (a_sgn ^ b_sgn) & ((req_fn != 3'd4) | (|req_b));
  assign req_rdy  = (state_q == IDLE) & ~kill;
  assign accept   = req_val & req_rdy;
  assign busy     = state_q != IDLE;
  assign last     = cnt_q == CW'(p_nbits - 1);
  assign add      = {1'b0, acc_q[2*p_nbits-1:p_nbits]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_step = {add, acc_q[p_nbits-1:1]};
  assign cand     = acc_q[2*p_nbits-1:p_nbits-1];
  assign diff     = cand - {1'b0, b_q};
  assign div_step = diff[p_nbits] ? {cand[p_nbits-1:0], acc_q[p_nbits-2:0], 1'b0}
                                  : {diff[p_nbits-1:0], acc_q[p_nbits-2:0], 1'b1};
  assign prod     = neg_q ? -acc_q : acc_q;
  assign dres     = fn_q[1] ? acc_q[2*p_nbits-1:p_nbits] : acc_q[p_nbits-1:0];
  assign res      = fn_q[2] ? (neg_q ? -dres : dres)
                  : (fn_q[1:0] == 2'd0) ? prod[p_nbits-1:0] : prod[2*p_nbits-1:p_nbits];
  assign resp_val    = (state_q == DONE) & ~kill;
  assign resp_result = resp_val ? res : '0;
  always_comb begin
    state_d = (state_q == IDLE) ? (accept ? CALC : IDLE)
            : kill ? IDLE
            : (state_q == CALC) ? (last ? DONE : CALC)
            : (resp_rdy ? IDLE : DONE);
    acc_d   = accept ? {{p_nbits{1'b0}}, a_mag}
            : (state_q == CALC && !kill) ? (fn_q[2] ? div_step : mul_step) : acc_q;
    cnt_d   = accept ? '0 : (state_q == CALC) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fn_q    <= '0;
      neg_q   <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        fn_q  <= req_fn;
        neg_q <= neg_d;
        b_q   <= b_mag;
      end
    end
  end
endmodule

// File: tb/tb_lab2_proc_muldiv_unit.sv
// tb_lab2_proc_muldiv_unit: random and directed checks of the muldiv unit against an arithmetic reference model
module tb_lab2_proc_muldiv_unit;
  logic clk = 0, reset = 0, kill = 0;
  always #5 clk = ~clk;
  logic        req_val = 0, resp_rdy = 0, req_rdy, resp_val, busy;
  logic [2:0]  req_fn = 0;
  logic [31:0] req_a = 0, req_b = 0, resp_result;
  logic        v8 = 0, rrdy8 = 1, rdy8, rv8, busy8;
  logic [2:0]  fn8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, res8;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [31:0] r; int acc;} exp_t;
  exp_t expq[$];
  bit seen = 0;
  logic [31:0] last_res = 0;

  lab2_proc_muldiv_unit #(.p_nbits(32)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy), .req_fn(req_fn),
    .req_a(req_a), .req_b(req_b), .kill(kill), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_result(resp_result), .busy(busy));
  lab2_proc_muldiv_unit #(.p_nbits(8)) dut8 (
    .clk(clk), .reset(reset), .req_val(v8), .req_rdy(rdy8), .req_fn(fn8),
    .req_a(a8), .req_b(b8), .kill(kill), .resp_val(rv8), .resp_rdy(rrdy8),
    .resp_result(res8), .busy(busy8));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] m, r;
    logic [63:0] p;
    longint ua, ub, sa, sb;
    m  = (w == 32) ? 32'hFFFF_FFFF : 32'hFF;
    ua = longint'(a & m);
    ub = longint'(b & m);
    sa = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb = b[w-1] ? ub - (longint'(1) << w) : ub;
    r  = 0;
    case (fn)
      3'd0: begin p = 64'(ua * ub); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = 32'(p >> w); end
      3'd2: begin p = 64'(ua * ub); r = 32'(p >> w); end
      3'd3: begin p = 64'(sa * ub); r = 32'(p >> w); end
      3'd4: r = (ub == 0) ? m : 32'(sa / sb);
      3'd5: r = (ub == 0) ? m : 32'(ua / ub);
      3'd6: r = (ub == 0) ? 32'(ua) : 32'(sa % sb);
      default: r = (ub == 0) ? 32'(ua) : 32'(ua % ub);
    endcase
    return r & m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resp_val) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_resp_val: got 1 want 0 at cycle %0d", cyc);
      end else begin
        chk("resp_result", 64'(resp_result), 64'(expq[0].r));
        chk("req_rdy_in_done", 64'(req_rdy), 64'd0);
        if (!seen) begin
          chk("latency", 64'(cyc - expq[0].acc), 64'd32);
          seen = 1;
        end
        if (resp_rdy) begin
          last_res = resp_result;
          void'(expq.pop_front());
          seen = 0;
        end
      end
    end else chk("result_zero_when_invalid", 64'(resp_result), 64'd0);
  end

  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    bit r;
    int n;
    exp_t e;
    req_val = 1; req_fn = fn; req_a = a; req_b = b;
    n = 0;
    do begin
      @(negedge clk); r = req_rdy;
      @(posedge clk); #1; n++;
    end while (!r && n < 100);
    req_val = 0;
    if (!r) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      e.r = model(fn, a, b, 32);
      e.acc = cyc;
      expq.push_back(e);
    end
  endtask

  task automatic wait_resp(input int bp);
    bit hs = 0;
    for (int n = 0; n < 200 && !hs; n++) begin
      resp_rdy = (bp == 0) || ($urandom_range(0, bp) == 0);
      @(negedge clk); hs = resp_val && resp_rdy;
      @(posedge clk); #1;
    end
    resp_rdy = 0;
    if (!hs) chk("resp_timeout", 64'd0, 64'd1);
    else chk("busy_after_handshake", 64'(busy), 64'd0);
  endtask

  task automatic wait_val();
    int n = 0;
    do begin @(negedge clk); n++; end while (!resp_val && n < 100);
    if (!resp_val) chk("resp_val_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  lf[12] = '{3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] la[12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                          32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] lb[12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                          32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] lw[12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                          32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
  logic [7:0]  bset[7] = '{8'h00, 8'h01, 8'h03, 8'h7F, 8'h80, 8'hFF, 8'h00};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_rdy", 64'(req_rdy), 64'd1);
    chk("rst_resp_val", 64'(resp_val), 64'd0);
    chk("rst_resp_result", 64'(resp_result), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    reset = 1;
    @(posedge clk); #1;
    chk("post_rst_busy", 64'(busy), 64'd0);
    // kill while idle blocks acceptance
    kill = 1; req_val = 1; #1;
    chk("kill_idle_rdy", 64'(req_rdy), 64'd0);
    @(posedge clk); #1;
    chk("kill_idle_busy", 64'(busy), 64'd0);
    kill = 0; req_val = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      issue(lf[i], la[i], lb[i]);
      wait_resp(0);
      chk($sformatf("literal_%0d", i), 64'(last_res), 64'(lw[i]));
    end
    // back-pressure in DONE, then next request one cycle after the handshake
    issue(3'd0, 32'd6, 32'd7);
    wait_val();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_resp_val", 64'(resp_val), 64'd1);
      chk("bp_result", 64'(resp_result), 64'd42);
      chk("bp_req_rdy", 64'(req_rdy), 64'd0);
    end
    resp_rdy = 1; req_val = 1; req_fn = 3'd5; req_a = 32'd100; req_b = 32'd7;
    @(posedge clk); #1;
    resp_rdy = 0;
    chk("hs_busy", 64'(busy), 64'd0);
    chk("hs_req_rdy", 64'(req_rdy), 64'd1);
    chk("hs_last_res", 64'(last_res), 64'd42);
    @(posedge clk); #1;
    req_val = 0;
    chk("next_accept_busy", 64'(busy), 64'd1);
    begin
      exp_t e;
      e.r = 32'd14; e.acc = cyc;
      expq.push_back(e);
    end
    wait_resp(0);
    // kill mid-CALC
    issue(3'd0, 32'd9, 32'd9);
    repeat (10) @(posedge clk);
    #1; kill = 1; #1;
    chk("kill_calc_rdy", 64'(req_rdy), 64'd0);
    @(posedge clk); #1;
    kill = 0;
    chk("kill_calc_busy", 64'(busy), 64'd0);
    void'(expq.pop_front()); seen = 0;
    repeat (40) @(posedge clk);
    #1;
    // kill in DONE drops resp_val immediately
    issue(3'd7, 32'd50, 32'd7);
    wait_val();
    @(posedge clk); #1; kill = 1; #1;
    chk("kill_done_val", 64'(resp_val), 64'd0);
    chk("kill_done_result", 64'(resp_result), 64'd0);
    @(posedge clk); #1;
    kill = 0;
    chk("kill_done_busy", 64'(busy), 64'd0);
    void'(expq.pop_front()); seen = 0;
    repeat (3) @(posedge clk);
    #1;
    // asynchronous reset mid-CALC
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (20) @(posedge clk);
    #1; reset = 0; #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_req_rdy", 64'(req_rdy), 64'd1);
    chk("arst_resp_val", 64'(resp_val), 64'd0);
    chk("arst_resp_result", 64'(resp_result), 64'd0);
    void'(expq.pop_front()); seen = 0;
    @(posedge clk); #1;
    reset = 1;
    repeat (40) @(posedge clk);
    #1;
    issue(3'd0, 32'd3, 32'd4);
    wait_resp(0);
    chk("mul_after_reset", 64'(last_res), 64'd12);
    for (int i = 0; i < 400; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      wait_resp(3);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    // 8-bit DIV/REM sweep over every dividend
    for (int a = 0; a < 256; a++)
      for (int j = 0; j < 7; j++)
        for (int f = 0; f < 2; f++) begin
          int n, t0;
          a8 = 8'(a);
          b8 = (j == 6) ? 8'($urandom) : bset[j];
          fn8 = (f == 0) ? 3'd4 : 3'd6;
          v8 = 1;
          @(negedge clk);
          if (!rdy8) chk("rdy8", 64'(rdy8), 64'd1);
          @(posedge clk); #1;
          v8 = 0; t0 = cyc; n = 0;
          do begin @(negedge clk); n++; end while (!rv8 && n < 30);
          chk("lat8", 64'(cyc - t0), 64'd8);
          chk($sformatf("res8_fn%0d_%0h_%0h", fn8, a8, b8), 64'(res8), 64'(model(fn8, 32'(a8), 32'(b8), 8)));
          @(posedge clk); #1;
        end
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
